// File: rtl/wave_shaper.sv
// wave_shaper: four-stage phase-to-sample pipeline (sine/square/triangle/saw, gain, offset, clamp).
// Define WAVE_SHAPER_PWM_EN to build the PWM output stage; otherwise pwm_out is tied low.
module wave_shaper #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sig_type,
  input  logic [7:0]        amplitude,
  input  logic [DATA_W-1:0] offset,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              pwm_out
);

  localparam int unsigned LUT_N  = 256;
  localparam int unsigned MAG_W  = 11;
  localparam int unsigned W_W    = 12;
  localparam int unsigned PROD_W = 21;
  localparam int unsigned P_W    = 13;
  localparam int unsigned SUM_W  = 14;
  localparam real         PI     = 3.14159265358979323846;

  // Quarter-wave sine magnitudes, sampled at bin centres so both quadrant mirrors are exact
  logic [MAG_W-1:0] sine_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam int MAG = int'(2047.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 1024.0));
    assign sine_lut[k] = MAG_W'(MAG);
  end

  // S1: capture inputs and detect a new address / shape
  logic [9:0]  a1;
  logic [3:0]  t1;
  logic [7:0]  amp1;
  logic [11:0] off1;
  logic        chg1;
  logic        prime;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1    <= '0;
      t1    <= '0;
      amp1  <= '0;
      off1  <= '0;
      chg1  <= 1'b0;
      prime <= 1'b1;
    end else begin
      chg1  <= prime || (addr != a1) || (sig_type != t1);
      a1    <= addr;
      t1    <= sig_type;
      amp1  <= amplitude;
      off1  <= offset;
      prime <= 1'b0;
    end
  end

  // S2: wave lookup, w held as a two's-complement bit pattern
  logic [7:0]     sin_idx;
  logic [W_W-1:0] sin_mag;
  logic [8:0]     tri_t;
  logic [W_W-1:0] w_next;

  always_comb begin
    sin_idx = a1[8] ? ~a1[7:0] : a1[7:0];
    sin_mag = {1'b0, sine_lut[sin_idx]};
    tri_t   = a1[9] ? ~a1[8:0] : a1[8:0];
    w_next  = '0;
    case (t1)
      4'd0:    w_next = a1[9] ? W_W'(-sin_mag) : sin_mag;
      4'd1:    w_next = a1[9] ? 12'h800 : 12'h7FF;
      4'd2:    w_next = {tri_t, 3'b000} - 12'd2048;
      4'd3:    w_next = {a1, 2'b00} - 12'd2048;
      default: w_next = '0;
    endcase
  end

  logic [W_W-1:0] w2;
  logic [7:0]     amp2;
  logic [11:0]    off2;
  logic           chg2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w2   <= '0;
      amp2 <= '0;
      off2 <= '0;
      chg2 <= 1'b0;
    end else begin
      w2   <= w_next;
      amp2 <= amp1;
      off2 <= off1;
      chg2 <= chg1;
    end
  end

  // S3: gain; dropping the low 8 product bits is a floor shift
  logic signed [PROD_W-1:0] prod;
  logic        [P_W-1:0]    p3;
  logic        [11:0]       off3;
  logic                     chg3;

  assign prod = $signed(w2) * $signed({1'b0, amp2});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3   <= '0;
      off3 <= '0;
      chg3 <= 1'b0;
    end else begin
      p3   <= prod[PROD_W-1:8];
      off3 <= off2;
      chg3 <= chg2;
    end
  end

  // S4: offset add at 14 bits, then clamp to the unsigned 12-bit range
  logic [SUM_W-1:0] sum;
  logic [11:0]      sat;

  always_comb begin
    sum = {p3[P_W-1], p3} + {2'b00, off3};
    sat = sum[11:0];
    if (sum[SUM_W-1])
      sat = '0;
    else if (sum[12])
      sat = 12'hFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample       <= DATA_W'(sat);
      sample_valid <= chg3;
    end
  end

`ifdef WAVE_SHAPER_PWM_EN
  // Duty reloads only at the period boundary so a mid-period sample change cannot cut a pulse
  logic [11:0] pwm_cnt;
  logic [11:0] duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < duty);
      if (pwm_cnt == 12'hFFF)
        duty <= 12'(sample);
      pwm_cnt <= pwm_cnt + 12'd1;
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_wave_shaper.sv
// Self-checking bench for wave_shaper: directed scenarios plus randomized traffic vs a behavioural model.
module tb_wave_shaper;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  addr;
  logic [3:0]  sig_type;
  logic [7:0]  amplitude;
  logic [11:0] offset;
  logic [11:0] sample;
  logic        sample_valid;
  logic        pwm_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int s;
    bit v;
  } exp_t;

  exp_t       exp_q[$];
  bit         m_prime;
  logic [9:0] m_addr;
  logic [3:0] m_type;

  wave_shaper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .sig_type     (sig_type),
    .amplitude    (amplitude),
    .offset       (offset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  // Sample from the shape definitions: full-period sine, ideal square/triangle/saw, floor gain, clamp
  function automatic int model_sample(int a, int t, int amp, int off);
    int w, p, s;
    case (t)
      0:       w = int'(2047.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 1024.0));
      1:       w = (a < 512) ? 2047 : -2048;
      2:       w = (a < 512) ? 8 * a - 2048 : 8 * (1023 - a) - 2048;
      3:       w = 4 * a - 2048;
      default: w = 0;
    endcase
    p = (w * amp) >>> 8;
    s = p + off;
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  function automatic void reset_model();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{0, 1'b0});
    m_prime = 1'b1;
    m_addr  = '0;
    m_type  = '0;
  endfunction

  // Advance one clock; returns what the outputs must show just after that edge
  task automatic step(output int es, output bit ev);
    bit chg;
    @(posedge clk);
    chg = m_prime || (addr != m_addr) || (sig_type != m_type);
    m_prime = 1'b0;
    m_addr  = addr;
    m_type  = sig_type;
    exp_q.push_back('{model_sample(int'(addr), int'(sig_type), int'(amplitude), int'(offset)), chg});
    #1;
    es = exp_q[0].s;
    ev = exp_q[0].v;
    void'(exp_q.pop_front());
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic set_in(input int a, input int t, input int amp, input int off);
    addr      = 10'(a);
    sig_type  = 4'(t);
    amplitude = 8'(amp);
    offset    = 12'(off);
  endtask

  task automatic test_reset();
    int es; bit ev; int pulses = 0;
    rst_n = 1'b0;
    set_in(0, 1, 255, 2048);
    #12;
    checks++;
    if (sample !== 12'd0 || sample_valid !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sample=%0d valid=%0b pwm=%0b, expected 0/0/0", sample, sample_valid, pwm_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 7; i++) begin
      step(es, ev);
      pulses += int'(sample_valid);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL reset_release cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
    checks++;
    if (pulses != 1 || sample !== 12'd4087) begin
      errors++;
      $display("FAIL reset_first_pulse: pulses=%0d sample=%0d, expected 1 and 4087", pulses, sample);
    end
  endtask

  task automatic test_square();
    int es; bit ev; int pulses = 0;
    set_in(512, 1, 255, 2048);
    for (int i = 0; i < 8; i++) begin
      step(es, ev);
      pulses += int'(sample_valid);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL square cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
    checks++;
    if (pulses != 1 || sample !== 12'd8) begin
      errors++;
      $display("FAIL square_hold: pulses=%0d sample=%0d, expected 1 and 8", pulses, sample);
    end
  endtask

  task automatic test_sine();
    int es; bit ev;
    int addrs[3] = '{256, 768, 0};
    int want[3]  = '{4087, 8, 2053};
    for (int k = 0; k < 3; k++) begin
      set_in(addrs[k], 0, 255, 2048);
      for (int i = 0; i < 4; i++) begin
        step(es, ev);
        checks++;
        if (sample !== 12'(es) || sample_valid !== ev) begin
          errors++;
          $display("FAIL sine a=%0d cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", addrs[k], i, sample, sample_valid, es, ev);
        end
      end
      checks++;
      if (sample !== 12'(want[k])) begin
        errors++;
        $display("FAIL sine_value a=%0d: sample=%0d, expected %0d", addrs[k], sample, want[k]);
      end
    end
  endtask

  task automatic test_triangle_zero();
    int es; bit ev; int pulses = 0;
    set_in(511, 2, 128, 2048);
    for (int i = 0; i < 4; i++) begin
      step(es, ev);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL triangle cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
    checks++;
    if (sample !== 12'd3068) begin
      errors++;
      $display("FAIL triangle_value: sample=%0d, expected 3068", sample);
    end
    sig_type = 4'd7;
    for (int i = 0; i < 5; i++) begin
      step(es, ev);
      pulses += int'(sample_valid);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL zero_wave cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
    checks++;
    if (pulses != 1 || sample !== 12'd2048) begin
      errors++;
      $display("FAIL zero_wave_value: pulses=%0d sample=%0d, expected 1 and 2048", pulses, sample);
    end
  endtask

  task automatic test_saturation();
    int es; bit ev;
    int st[2]   = '{3, 1};
    int off[2]  = '{0, 4095};
    int want[2] = '{0, 4095};
    for (int k = 0; k < 2; k++) begin
      set_in(0, st[k], 255, off[k]);
      for (int i = 0; i < 4; i++) begin
        step(es, ev);
        checks++;
        if (sample !== 12'(es) || sample_valid !== ev) begin
          errors++;
          $display("FAIL saturate%0d cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", k, i, sample, sample_valid, es, ev);
        end
      end
      checks++;
      if (sample !== 12'(want[k])) begin
        errors++;
        $display("FAIL saturate_value%0d: sample=%0d, expected %0d", k, sample, want[k]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample !== 12'd0 || sample_valid !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sample=%0d valid=%0b pwm=%0b, expected 0/0/0", sample, sample_valid, pwm_out);
    end
    apply_reset();
  endtask

  task automatic test_wrap_and_params();
    int es; bit ev;
    int seq[8] = '{1021, 1022, 1023, 0, 1, 1, 1, 1};
    set_in(1020, 3, 255, 2048);
    for (int i = 0; i < 8; i++) begin
      step(es, ev);
      addr = 10'(seq[i]);
      if (i == 5) amplitude = 8'd100;
      if (i == 6) offset = 12'd1000;
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL wrap cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(es, ev);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL param_change cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
    end
  endtask

  task automatic test_random();
    int es; bit ev; int r;
    for (int i = 0; i < 400; i++) begin
      step(es, ev);
      checks++;
      if (sample !== 12'(es) || sample_valid !== ev) begin
        errors++;
        $display("FAIL random cyc%0d: sample=%0d valid=%0b, expected %0d/%0b", i, sample, sample_valid, es, ev);
      end
      r = int'($urandom_range(0, 99));
      if (r < 30) addr = addr + 10'd1;
      else if (r < 50) addr = 10'($urandom());
      r = int'($urandom_range(0, 99));
      if (r < 8) sig_type = 4'($urandom_range(0, 3));
      else if (r < 10) sig_type = 4'($urandom_range(4, 15));
      if ($urandom_range(0, 9) == 0) amplitude = 8'($urandom());
      if ($urandom_range(0, 9) == 0) offset = 12'($urandom());
    end
  endtask

  task automatic test_pwm();
`ifdef WAVE_SHAPER_PWM_EN
    int hi0 = 0;
    int hi1 = 0;
    set_in(0, 1, 0, 1024);
    apply_reset();
    for (int n = 1; n <= 12288; n++) begin
      @(posedge clk);
      #1;
      if (n >= 4097 && n <= 8192) hi0 += int'(pwm_out);
      if (n >= 8193) hi1 += int'(pwm_out);
      if (n == 6000) offset = 12'd3000;
    end
    checks++;
    if (hi0 != 1024) begin
      errors++;
      $display("FAIL pwm_duty_1024: high=%0d, expected 1024", hi0);
    end
    checks++;
    if (hi1 != 3000) begin
      errors++;
      $display("FAIL pwm_duty_3000: high=%0d, expected 3000", hi1);
    end
`else
    int hi = 0;
    set_in(0, 1, 255, 4095);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      hi += int'(pwm_out);
      if (n == 150) addr = 10'd600;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL pwm_tied_low: high=%0d, expected 0", hi);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_square();
    test_sine();
    test_triangle_zero();
    test_saturation();
    test_wrap_and_params();
    test_random();
    test_pwm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
